// File: rtl/ps2_arrow_decoder.sv
// PS/2 extended arrow-key decoder: E0/F0 prefix parser, held levels, move pulses.
// Define KEY_REPEAT_EN to add per-direction auto-repeat of move_pulse.
module ps2_arrow_decoder #(
    parameter int TIMEOUT_CYCLES = 500000
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic [3:0] move_pulse,
    output logic [7:0] key_code,
    output logic       seq_error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [3:0]    raw_q, raw_d;
    logic [3:0]    res_q, res_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [7:0]    code_q, code_d;
    logic          last_h_q, last_h_d;
    logic          last_v_q, last_v_d;
    logic [3:0]    arrow;
    logic [3:0]    make_ev;
    logic [3:0]    brk_ev;
    logic [3:0]    fresh;
    logic          is_pfx;

    // Map the current byte to a one-hot arrow {down,up,right,left}
    always_comb begin
        arrow = 4'b0000;
        unique case (ps2_key_data)
            8'h6B:   arrow = 4'b0001;
            8'h74:   arrow = 4'b0010;
            8'h75:   arrow = 4'b0100;
            8'h72:   arrow = 4'b1000;
            default: arrow = 4'b0000;
        endcase
    end

    assign is_pfx = (ps2_key_data == 8'hE0) || (ps2_key_data == 8'hF0);

    // Prefix parser and timeout; a strobe always beats an expiring timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        make_ev = 4'b0000;
        brk_ev  = 4'b0000;
        if (ps2_key_pressed) begin
            timer_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == 8'hE0)
                        state_d = S_EXT;
                    else if (ps2_key_data == 8'hF0)
                        state_d = S_BRK;
                end
                S_EXT: begin
                    if (ps2_key_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        make_ev = arrow;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: state_d = S_IDLE;
                S_EXT_BRK: begin
                    // a prefix where a key code belongs means a corrupted stream
                    brk_ev  = arrow;
                    err_d   = is_pfx;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (timer_q == T_LAST) begin
                timer_d = '0;
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Raw key state, per-axis last-pressed priority and resolved outputs
    always_comb begin
        raw_d    = (raw_q | make_ev) & ~brk_ev;
        last_h_d = last_h_q;
        last_v_d = last_v_q;
        if (make_ev[1])
            last_h_d = 1'b1;
        else if (make_ev[0])
            last_h_d = 1'b0;
        if (make_ev[3])
            last_v_d = 1'b1;
        else if (make_ev[2])
            last_v_d = 1'b0;
        res_d[0] = raw_d[0] & ~(raw_d[1] & last_h_d);
        res_d[1] = raw_d[1] & ~(raw_d[0] & ~last_h_d);
        res_d[2] = raw_d[2] & ~(raw_d[3] & last_v_d);
        res_d[3] = raw_d[3] & ~(raw_d[2] & ~last_v_d);
        code_d   = code_q;
        if (|make_ev)
            code_d = ps2_key_data;
    end

    // Typematic makes of an already-held key do not pulse
    assign fresh = make_ev & ~raw_q;

`ifdef KEY_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q [4];
    logic [RW-1:0] rpt_d [4];
    logic [3:0]    rpt_fire;

    // Repeat counters run from the initial pulse while the output stays high
    always_comb begin
        rpt_fire = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rpt_d[k] = rpt_q[k];
            if (!res_d[k] || !res_q[k]) begin
                rpt_d[k] = '0;
            end else if (rpt_q[k] == R_LAST) begin
                rpt_d[k]    = '0;
                rpt_fire[k] = 1'b1;
            end else begin
                rpt_d[k] = rpt_q[k] + 1'b1;
            end
        end
    end

    // Repeat counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++)
                rpt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                rpt_q[k] <= rpt_d[k];
        end
    end

    assign pulse_d = fresh | rpt_fire;
`else
    assign pulse_d = fresh;
`endif

    // State, timer and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            err_q    <= 1'b0;
            raw_q    <= 4'b0000;
            res_q    <= 4'b0000;
            pulse_q  <= 4'b0000;
            code_q   <= 8'h00;
            last_h_q <= 1'b0;
            last_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            raw_q    <= raw_d;
            res_q    <= res_d;
            pulse_q  <= pulse_d;
            code_q   <= code_d;
            last_h_q <= last_h_d;
            last_v_q <= last_v_d;
        end
    end

    assign left       = res_q[0];
    assign right      = res_q[1];
    assign up         = res_q[2];
    assign down       = res_q[3];
    assign move_pulse = pulse_q;
    assign key_code   = code_q;
    assign seq_error  = err_q;

endmodule
